// File: rtl/ariane_pkg.sv
// Shared frontend/execute types plus the BHT counter helpers.
package ariane_pkg;

  localparam int unsigned VLEN = 64;

  localparam logic [1:0] BHT_CNT_WEAK_T  = 2'b10;
  localparam logic [1:0] BHT_CNT_WEAK_NT = 2'b01;

  typedef struct packed {
    logic valid;
    logic taken;
  } bht_prediction_t;

  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic [VLEN-1:0] target_address;
    logic            is_mispredict;
    logic            is_taken;
    logic            conditional;
  } bp_resolve_t;

  typedef enum logic {
    BHT_CLEAR = 1'b0,
    BHT_RUN   = 1'b1
  } bht_state_e;

  // 2-bit saturating counter step: taken counts up, not-taken counts down.
  function automatic logic [1:0] sat_cnt_upd(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    res = cnt;
    if (taken) begin
      if (cnt != 2'b11) res = cnt + 2'b01;
    end else begin
      if (cnt != 2'b00) res = cnt - 2'b01;
    end
    return res;
  endfunction

endpackage

// File: rtl/bht_resolve_updater.sv
// Branch history table: 2-bit counters updated from execute resolutions,
// combinational lookup with forwarding of the in-flight update, sweep clear.
module bht_resolve_updater
  import ariane_pkg::*;
#(
  parameter int unsigned NR_ENTRIES = 64,
  parameter int unsigned IDX_OFFSET = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_bp_i,
  input  logic            debug_mode_i,
  input  logic [VLEN-1:0] vpc_i,
  input  bp_resolve_t     resolved_branch_i,
  output bht_prediction_t bht_prediction_o,
  output logic            busy_o
);

  localparam int unsigned IDX_W = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_ENTRIES - 1);

  bht_state_e       state_q;
  logic [IDX_W-1:0] clr_idx_q;
  logic             stage_valid_q;
  logic [IDX_W-1:0] stage_idx_q;
  logic             stage_taken_q;

  // Table storage: deliberately without reset, the sweep invalidates it.
  logic [NR_ENTRIES-1:0] valid_q;
  logic [1:0]            cnt_q [NR_ENTRIES];

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] cap_idx;
  logic             capture;
  logic             stage_wr;
  logic [1:0]       upd_cnt;
  logic             unused_bits;

  assign rd_idx  = vpc_i[IDX_OFFSET +: IDX_W];
  assign cap_idx = resolved_branch_i.pc[IDX_OFFSET +: IDX_W];

  assign capture = resolved_branch_i.valid && resolved_branch_i.conditional &&
                   !debug_mode_i && (state_q == BHT_RUN) && !flush_bp_i;

  assign stage_wr = stage_valid_q && !flush_bp_i && (state_q == BHT_RUN);

  assign unused_bits = ^{vpc_i, resolved_branch_i};

  // Post-update counter for the staged entry; an invalid entry starts weak.
  always_comb begin
    upd_cnt = BHT_CNT_WEAK_NT;
    if (valid_q[stage_idx_q]) begin
      upd_cnt = sat_cnt_upd(cnt_q[stage_idx_q], stage_taken_q);
    end else if (stage_taken_q) begin
      upd_cnt = BHT_CNT_WEAK_T;
    end
  end

  // Lookup, forwarding the staged update when it targets the same index.
  always_comb begin
    bht_prediction_o = '0;
    if (!busy_o) begin
      if (stage_valid_q && (stage_idx_q == rd_idx)) begin
        bht_prediction_o.valid = 1'b1;
        bht_prediction_o.taken = upd_cnt[1];
      end else begin
        bht_prediction_o.valid = valid_q[rd_idx];
        bht_prediction_o.taken = cnt_q[rd_idx][1];
      end
    end
  end

  // Control: clear/run FSM, sweep pointer and the capture stage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= BHT_CLEAR;
      clr_idx_q     <= '0;
      stage_valid_q <= 1'b0;
      stage_idx_q   <= '0;
      stage_taken_q <= 1'b0;
      busy_o        <= 1'b1;
    end else begin
      stage_valid_q <= capture;
      if (capture) begin
        stage_idx_q   <= cap_idx;
        stage_taken_q <= resolved_branch_i.is_taken;
      end
      case (state_q)
        BHT_CLEAR: begin
          if (flush_bp_i) begin
            clr_idx_q <= '0;
          end else if (clr_idx_q == LAST_IDX) begin
            clr_idx_q <= '0;
            state_q   <= BHT_RUN;
            busy_o    <= 1'b0;
          end else begin
            clr_idx_q <= clr_idx_q + IDX_W'(1);
          end
        end
        BHT_RUN: begin
          if (flush_bp_i) begin
            clr_idx_q <= '0;
            state_q   <= BHT_CLEAR;
            busy_o    <= 1'b1;
          end
        end
        default: begin
          state_q <= BHT_CLEAR;
          busy_o  <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == BHT_CLEAR) begin
      valid_q[clr_idx_q] <= 1'b0;
    end else if (stage_wr) begin
      valid_q[stage_idx_q] <= 1'b1;
      cnt_q[stage_idx_q]   <= upd_cnt;
    end
  end

endmodule

// File: tb/tb_bht_resolve_updater.sv
// Directed self-checking bench for bht_resolve_updater.
module tb_bht_resolve_updater;
  import ariane_pkg::*;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            dbg;
  logic [VLEN-1:0] vpc;
  bp_resolve_t     rb;
  bht_prediction_t pred;
  logic            busy;

  int checks = 0;
  int passed = 0;

  localparam logic [VLEN-1:0] PC_A     = 64'h0000_0000_8000_0010;
  localparam logic [VLEN-1:0] PC_ALIAS = 64'h0000_0000_8000_0090;
  localparam logic [VLEN-1:0] PC_B     = 64'h0000_0000_8000_0020;
  localparam logic [VLEN-1:0] PC_C     = 64'h0000_0000_8000_0040;
  localparam logic [VLEN-1:0] PC_D     = 64'h0000_0000_8000_0060;

  bht_resolve_updater #(.NR_ENTRIES(64), .IDX_OFFSET(1)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .flush_bp_i        (flush),
    .debug_mode_i      (dbg),
    .vpc_i             (vpc),
    .resolved_branch_i (rb),
    .bht_prediction_o  (pred),
    .busy_o            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic [VLEN-1:0] pc, input logic taken, input logic cond);
    rb             = '0;
    rb.valid       = 1'b1;
    rb.pc          = pc;
    rb.is_taken    = taken;
    rb.conditional = cond;
    step();
    rb = '0;
  endtask

  task automatic lookup(input logic [VLEN-1:0] pc, output bht_prediction_t p);
    vpc = pc;
    #1;
    p = pred;
  endtask

  task automatic test_reset();
    int  n;
    logic bad;
    bht_prediction_t p;
    rst = 1'b1;
    step();
    step();
    checks++;
    if (busy !== 1'b1 || pred !== 2'b00) $display("FAIL reset_state: busy=%b pred=%b expected busy=1 pred=00", busy, pred);
    else passed++;
    rst = 1'b0;
    n = 0;
    bad = 1'b0;
    vpc = PC_A;
    while (busy === 1'b1 && n < 300) begin
      if (pred.valid !== 1'b0) bad = 1'b1;
      n++;
      step();
    end
    checks++;
    if (n != 64) $display("FAIL reset_busy_cycles: got %0d expected 64", n);
    else passed++;
    checks++;
    if (bad) $display("FAIL reset_valid_while_busy: got 1 expected 0");
    else passed++;
    bad = 1'b0;
    for (int i = 0; i < 64; i++) begin
      lookup(VLEN'(i) << 1, p);
      if (p.valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) $display("FAIL reset_all_invalid: some entry valid or busy, expected all invalid busy=0");
    else passed++;
  endtask

  task automatic test_first_update();
    bht_prediction_t p;
    resolve(PC_A, 1'b1, 1'b1);
    lookup(PC_A, p);
    checks++;
    if (p !== 2'b11) $display("FAIL first_taken: got %b expected 11", p);
    else passed++;
    resolve(PC_A, 1'b0, 1'b1);
    lookup(PC_A, p);
    checks++;
    if (p !== 2'b10) $display("FAIL first_not_taken_fwd: got %b expected 10", p);
    else passed++;
    step();
    lookup(PC_A, p);
    checks++;
    if (p !== 2'b10) $display("FAIL first_not_taken_array: got %b expected 10", p);
    else passed++;
  endtask

  task automatic test_saturation();
    // Outcomes and predicted direction after each update: 10,11,11,11,10,01,00,00,01,10.
    logic tk  [10] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
    logic exp [10] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 1};
    bht_prediction_t p;
    for (int i = 0; i < 10; i++) begin
      resolve(PC_B, tk[i], 1'b1);
      lookup(PC_B, p);
      checks++;
      if (p !== {1'b1, exp[i]}) $display("FAIL saturation_step%0d: got %b expected %b", i, p, {1'b1, exp[i]});
      else passed++;
    end
    step();
  endtask

  task automatic test_filtering();
    bht_prediction_t p;
    resolve(PC_C, 1'b1, 1'b0);
    lookup(PC_C, p);
    checks++;
    if (p.valid !== 1'b0) $display("FAIL filter_jalr: got valid=%b expected 0", p.valid);
    else passed++;
    dbg = 1'b1;
    resolve(PC_C, 1'b1, 1'b1);
    lookup(PC_C, p);
    checks++;
    if (p.valid !== 1'b0) $display("FAIL filter_debug_fwd: got valid=%b expected 0", p.valid);
    else passed++;
    dbg = 1'b0;
    step();
    lookup(PC_C, p);
    checks++;
    if (p.valid !== 1'b0) $display("FAIL filter_debug_array: got valid=%b expected 0", p.valid);
    else passed++;
  endtask

  task automatic test_flush();
    int n;
    bht_prediction_t p;
    resolve(PC_D, 1'b1, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      n++;
      step();
    end
    checks++;
    if (n != 64) $display("FAIL flush_busy_cycles: got %0d expected 64", n);
    else passed++;
    lookup(PC_D, p);
    checks++;
    if (p.valid !== 1'b0) $display("FAIL flush_dropped_write: got valid=%b expected 0", p.valid);
    else passed++;
    lookup(PC_A, p);
    checks++;
    if (p.valid !== 1'b0) $display("FAIL flush_cleared_entry: got valid=%b expected 0", p.valid);
    else passed++;
    flush = 1'b1;
    step();
    flush = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      n++;
      flush = (n == 30);
      step();
    end
    flush = 1'b0;
    checks++;
    if (n != 94) $display("FAIL flush_restart_cycles: got %0d expected 94", n);
    else passed++;
  endtask

  task automatic test_aliasing();
    bht_prediction_t p;
    resolve(PC_A, 1'b1, 1'b1);
    lookup(PC_ALIAS, p);
    checks++;
    if (p !== 2'b11) $display("FAIL alias_fwd: got %b expected 11", p);
    else passed++;
    step();
    lookup(PC_ALIAS, p);
    checks++;
    if (p !== 2'b11) $display("FAIL alias_array: got %b expected 11", p);
    else passed++;
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    dbg   = 1'b0;
    vpc   = '0;
    rb    = '0;
    test_reset();
    test_first_update();
    test_saturation();
    test_filtering();
    test_flush();
    test_aliasing();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
